// File: rtl/impix_system_pio_in_ext.sv
// Avalon-MM input PIO: two-flop sync, per-channel debounce, rise/fall edge capture (W1C), masked IRQ.
// Optional feature macro: PIO_DEBOUNCE_EN builds the debounce counters and the DEBOUNCE register.
module impix_system_pio_in_ext #(
    parameter int                  WIDTH    = 4,
    parameter int                  DB_CNT_W = 16,
    parameter logic [DB_CNT_W-1:0] DB_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] accept;
    logic             wr_en;
    logic             unused_wdata;
`ifdef PIO_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] db_thresh_q, db_thresh_d;
    logic [DB_CNT_W-1:0] cnt_q [WIDTH];
    logic [DB_CNT_W-1:0] cnt_d [WIDTH];
`endif

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        accept     = '0;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        readdata_d = '0;
`ifdef PIO_DEBOUNCE_EN
        db_thresh_d = db_thresh_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == db_thresh_q) begin
                cnt_d[i]  = '0;
                accept[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_CNT_W'(1);
            end
        end
        // A new threshold restarts every count; nothing is accepted on that edge.
        if (wr_en && address == ADDR_DEBOUNCE) begin
            db_thresh_d = writedata[DB_CNT_W-1:0];
            accept      = '0;
            for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
        end
`else
        accept = sync2_q ^ level_q;
`endif
        level_d = (level_q & ~accept) | (sync2_q & accept);

        edge_cap_d = edge_cap_q;
        if (wr_en && address == ADDR_EDGE_CAP) edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
        // Set is applied after the clear so an event coinciding with W1C is never lost.
        edge_cap_d = edge_cap_d | (accept & ((sync2_q & rise_en_q) | (~sync2_q & fall_en_q)));

        if (wr_en && address == ADDR_RISE_EN)  rise_en_d  = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_FALL_EN)  fall_en_d  = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_IRQ_MASK) irq_mask_d = writedata[WIDTH-1:0];

        case (address)
            ADDR_DATA:     readdata_d = 32'(level_q);
            ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
            ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
            ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
`ifdef PIO_DEBOUNCE_EN
            ADDR_DEBOUNCE: readdata_d = 32'(db_thresh_q);
`endif
            default:       readdata_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '1;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    // NOTE: the counters are individual flops, not a RAM, so resetting the whole array is legal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_thresh_q <= DB_RESET;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            db_thresh_q <= db_thresh_d;
            cnt_q       <= cnt_d;
        end
    end
`endif

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
